// File: rtl/agc_cdu_pkg.sv
// agc_cdu_pkg: state encodings and saturation helper
// shared by the CDU pulse generator files.
package agc_cdu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT_ACK,
    S_GAP
  } cdu_state_e;

  // Largest magnitude a w-bit signed accumulator may hold.
  function automatic longint sat_lim(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

endpackage

// File: rtl/cdu_pace_timer.sv
// cdu_pace_timer: loadable down-counter with hold, stops at zero.
// Paces pulse width, ack gap and the optional ack timeout.
module cdu_pace_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         hold,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!hold && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cdu_pulse_gen.sv
// cdu_pulse_gen: signed CDU deltas -> paced PCDU/MCDU pulses.
// Define CDU_TIMEOUT_EN to add the sticky ack-timeout path.
module cdu_pulse_gen
  import agc_cdu_pkg::*;
#(
  parameter int ACC_W       = 16,
  parameter int PULSE_CYC   = 2,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    CLOCK,
  input  logic                    SIM_RST,
  input  logic                    DELTA_VALID,
  output logic                    DELTA_READY,
  input  logic signed [ACC_W-1:0] DELTA,
  input  logic                    CDUSTB_n,
  output logic                    PCDU,
  output logic                    MCDU,
  output logic signed [ACC_W-1:0] PENDING,
  output logic                    BUSY,
  output logic                    TIMEOUT
);

  if (PULSE_CYC < 1 || GAP_CYC < 1 || TIMEOUT_CYC < 1)
  begin : g_bad_cfg
    $error("cdu_pulse_gen: cycle counts must be >= 1");
  end

  localparam int PG_MAX =
    (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
`ifdef CDU_TIMEOUT_EN
  localparam int CNT_MAX =
    (TIMEOUT_CYC > PG_MAX) ? TIMEOUT_CYC : PG_MAX;
`else
  localparam int CNT_MAX = PG_MAX;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam int SW    = ACC_W + 2;

  localparam logic signed [SW-1:0] LIM_P =
    SW'(sat_lim(ACC_W));
  localparam logic signed [SW-1:0] LIM_N = -LIM_P;

  cdu_state_e state_q, state_d;
  logic pcdu_q, pcdu_d;
  logic mcdu_q, mcdu_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [1:0] step;
  logic signed [SW-1:0] add_w, sum_w;
  logic accept;
  logic t_load, t_hold, t_zero;
  logic [CNT_W-1:0] t_val;
`ifdef CDU_TIMEOUT_EN
  logic to_q, to_d;
`endif

  assign DELTA_READY = !SIM_RST;
  assign accept      = DELTA_VALID && !SIM_RST;

  cdu_pace_timer #(.W(CNT_W)) u_timer (
    .clk      (CLOCK),
    .rst      (SIM_RST),
    .load     (t_load),
    .load_val (t_val),
    .hold     (t_hold),
    .zero     (t_zero)
  );

  always_comb begin
    state_d = state_q;
    pcdu_d  = pcdu_q;
    mcdu_d  = mcdu_q;
    step    = 2'sd0;
    t_load  = 1'b0;
    t_val   = '0;
    t_hold  = 1'b0;
`ifdef CDU_TIMEOUT_EN
    to_d    = to_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (acc_q != '0) begin
          state_d = S_PULSE;
          t_load  = 1'b1;
          t_val   = CNT_W'(PULSE_CYC - 1);
          if (acc_q[ACC_W-1]) begin
            mcdu_d = 1'b1;
            step   = -2'sd1;
          end else begin
            pcdu_d = 1'b1;
            step   = 2'sd1;
          end
        end
      end
      S_PULSE: begin
        if (t_zero) begin
          state_d = S_WAIT_ACK;
          pcdu_d  = 1'b0;
          mcdu_d  = 1'b0;
`ifdef CDU_TIMEOUT_EN
          t_load  = 1'b1;
          t_val   = CNT_W'(TIMEOUT_CYC - 1);
`endif
        end
      end
      S_WAIT_ACK: begin
        if (!CDUSTB_n) begin
          state_d = S_GAP;
          t_load  = 1'b1;
          t_val   = CNT_W'(GAP_CYC - 1);
        end
`ifdef CDU_TIMEOUT_EN
        else if (t_zero) begin
          state_d = S_GAP;
          t_load  = 1'b1;
          t_val   = CNT_W'(GAP_CYC - 1);
          to_d    = 1'b1;
        end
`endif
      end
      S_GAP: begin
        // Gap only counts cycles with the ack released.
        t_hold = !CDUSTB_n;
        if (CDUSTB_n && t_zero) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    add_w = accept ? SW'(DELTA) : '0;
    sum_w = SW'(acc_q) + add_w - SW'(step);
    if (sum_w > LIM_P) begin
      acc_d = LIM_P[ACC_W-1:0];
    end else if (sum_w < LIM_N) begin
      acc_d = LIM_N[ACC_W-1:0];
    end else begin
      acc_d = sum_w[ACC_W-1:0];
    end
  end

  always_ff @(posedge CLOCK) begin
    if (SIM_RST) begin
      state_q <= S_IDLE;
      pcdu_q  <= 1'b0;
      mcdu_q  <= 1'b0;
      acc_q   <= '0;
`ifdef CDU_TIMEOUT_EN
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pcdu_q  <= pcdu_d;
      mcdu_q  <= mcdu_d;
      acc_q   <= acc_d;
`ifdef CDU_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign PCDU    = pcdu_q;
  assign MCDU    = mcdu_q;
  assign PENDING = acc_q;
  assign BUSY    = (state_q != S_IDLE) || (acc_q != '0);
`ifdef CDU_TIMEOUT_EN
  assign TIMEOUT = to_q;
`else
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_cdu_pulse_gen.sv
// tb_cdu_pulse_gen: directed vector table plus hand-written
// corner sequences for cdu_pulse_gen.
module tb_cdu_pulse_gen;

  localparam int ACC_W       = 16;
  localparam int PULSE_CYC   = 2;
  localparam int GAP_CYC     = 4;
  localparam int TIMEOUT_CYC = 8;

  logic clk = 1'b0;
  logic sim_rst = 1'b1;
  logic dv = 1'b1;
  logic stb = 1'b1;
  logic signed [ACC_W-1:0] delta = 16'sd5;
  logic ready, pcdu, mcdu, busy, tmo;
  logic signed [ACC_W-1:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  cdu_pulse_gen #(
    .ACC_W       (ACC_W),
    .PULSE_CYC   (PULSE_CYC),
    .GAP_CYC     (GAP_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLOCK       (clk),
    .SIM_RST     (sim_rst),
    .DELTA_VALID (dv),
    .DELTA_READY (ready),
    .DELTA       (delta),
    .CDUSTB_n    (stb),
    .PCDU        (pcdu),
    .MCDU        (mcdu),
    .PENDING     (pending),
    .BUSY        (busy),
    .TIMEOUT     (tmo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic signed [ACC_W-1:0] d;
    logic s;
    logic p;
    logic m;
    int   pend;
    logic b;
  } vec_t;

  vec_t tv[29];

  function automatic vec_t mk(int v, int d, int s,
                              int p, int m, int pend, int b);
    vec_t r;
    r.v = v[0];
    r.d = ACC_W'(d);
    r.s = s[0];
    r.p = p[0];
    r.m = m[0];
    r.pend = pend;
    r.b = b[0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Acks each pulse (stb low one cycle, two cycles after it ends)
  // and tallies pulses until the block goes idle.
  task automatic serve(input int budget, input string nm,
                       output int p_r, output int m_r);
    logic pp, pm, prev_s;
    int w, cd, gap, ovl;
    p_r = 0; m_r = 0; pp = pcdu; pm = mcdu;
    w = -1; cd = 0; gap = -1; ovl = 0;
    for (int i = 0; i < budget; i++) begin
      prev_s = stb;
      if (cd > 0) begin
        cd--;
        stb = (cd == 0) ? 1'b0 : 1'b1;
      end else begin
        stb = 1'b1;
      end
      if (!prev_s && stb) gap = 0;
      tick();
      if (gap >= 0) gap++;
      if (pcdu && mcdu) ovl++;
      if ((pcdu && !pp) || (mcdu && !pm)) begin
        if (pcdu && !pp) p_r++;
        else m_r++;
        w = 1;
        if (gap >= 0)
          chk({nm, " gap>=GAP_CYC"}, longint'(gap >= GAP_CYC), 1);
        gap = -1;
      end else if (pcdu || mcdu) begin
        if (w > 0) w++;
      end else if (pp || pm) begin
        if (w > 0) chk({nm, " width"}, w, PULSE_CYC);
        w = -1;
        cd = 2;
      end
      pp = pcdu; pm = mcdu;
      if (!busy) break;
    end
    stb = 1'b1;
    chk({nm, " idle in budget"}, busy, 0);
    chk({nm, " no overlap"}, ovl, 0);
  endtask

  task automatic do_reset();
    sim_rst = 1'b1; dv = 1'b0; stb = 1'b1;
    tick();
    sim_rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_r, m_r, cnt;

    // DELTA =+3, ack one cycle low two cycles after each pulse
    tv[0]  = mk(1, 3, 1, 0, 0, 3, 1);
    tv[1]  = mk(0, 0, 1, 1, 0, 2, 1);
    tv[2]  = mk(0, 0, 1, 1, 0, 2, 1);
    tv[3]  = mk(0, 0, 1, 0, 0, 2, 1);
    tv[4]  = mk(0, 0, 1, 0, 0, 2, 1);
    tv[5]  = mk(0, 0, 0, 0, 0, 2, 1);
    tv[6]  = mk(0, 0, 1, 0, 0, 2, 1);
    tv[7]  = mk(0, 0, 1, 0, 0, 2, 1);
    tv[8]  = mk(0, 0, 1, 0, 0, 2, 1);
    tv[9]  = mk(0, 0, 1, 0, 0, 2, 1);
    tv[10] = mk(0, 0, 1, 1, 0, 1, 1);
    tv[11] = mk(0, 0, 1, 1, 0, 1, 1);
    tv[12] = mk(0, 0, 1, 0, 0, 1, 1);
    tv[13] = mk(0, 0, 1, 0, 0, 1, 1);
    tv[14] = mk(0, 0, 0, 0, 0, 1, 1);
    tv[15] = mk(0, 0, 1, 0, 0, 1, 1);
    tv[16] = mk(0, 0, 1, 0, 0, 1, 1);
    tv[17] = mk(0, 0, 1, 0, 0, 1, 1);
    tv[18] = mk(0, 0, 1, 0, 0, 1, 1);
    tv[19] = mk(0, 0, 1, 1, 0, 0, 1);
    tv[20] = mk(0, 0, 1, 1, 0, 0, 1);
    tv[21] = mk(0, 0, 1, 0, 0, 0, 1);
    tv[22] = mk(0, 0, 1, 0, 0, 0, 1);
    tv[23] = mk(0, 0, 0, 0, 0, 0, 1);
    tv[24] = mk(0, 0, 1, 0, 0, 0, 1);
    tv[25] = mk(0, 0, 1, 0, 0, 0, 1);
    tv[26] = mk(0, 0, 1, 0, 0, 0, 1);
    tv[27] = mk(0, 0, 1, 0, 0, 0, 0);
    tv[28] = mk(0, 0, 1, 0, 0, 0, 0);

    // Reset with a valid delta offered: nothing may transfer
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst pcdu", pcdu, 0);
      chk("rst mcdu", mcdu, 0);
      chk("rst pending", pending, 0);
      chk("rst busy", busy, 0);
      chk("rst ready", ready, 0);
      chk("rst timeout", tmo, 0);
    end
    sim_rst = 1'b0; dv = 1'b0; delta = '0;
    #1;
    chk("ready after rst", ready, 1);
    tick();
    chk("no xfer in rst", pending, 0);

    for (int i = 0; i < 29; i++) begin
      dv = tv[i].v; delta = tv[i].d; stb = tv[i].s;
      tick();
      chk($sformatf("tv%0d pcdu", i), pcdu, tv[i].p);
      chk($sformatf("tv%0d mcdu", i), mcdu, tv[i].m);
      chk($sformatf("tv%0d pending", i), pending, tv[i].pend);
      chk($sformatf("tv%0d busy", i), busy, tv[i].b);
    end
    dv = 1'b0; stb = 1'b1;

    // Sign reversal during the first pulse
    dv = 1'b1; delta = 16'sd2;
    tick();
    dv = 1'b0;
    chk("rev acc", pending, 2);
    tick();
    chk("rev p1 on", pcdu, 1);
    chk("rev acc after step", pending, 1);
    dv = 1'b1; delta = -16'sd5;
    tick();
    dv = 1'b0;
    chk("rev acc neg", pending, -4);
    chk("rev p1 held", pcdu, 1);
    chk("rev no mcdu yet", mcdu, 0);
    serve(300, "rev", p_r, m_r);
    chk("rev extra pcdu", p_r, 0);
    chk("rev mcdu count", m_r, 4);
    chk("rev pending end", pending, 0);

    // Ack low during PULSE is ignored, then a stretched ack
    dv = 1'b1; delta = 16'sd2;
    tick();
    dv = 1'b0;
    tick();
    chk("str pulse on", pcdu, 1);
    stb = 1'b0;
    tick();
    stb = 1'b1;
    tick();
    chk("str pulse off", pcdu, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (pcdu) cnt++;
    end
    chk("ack not latched", cnt, 0);
    chk("str pending", pending, 1);
    stb = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pcdu || mcdu) cnt++;
    end
    chk("gap held by ack", cnt, 0);
    stb = 1'b1;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (pcdu) begin
        cnt = i;
        break;
      end
    end
    chk("gap after release",
        longint'(cnt >= GAP_CYC && cnt <= GAP_CYC + 1), 1);
    serve(100, "str", p_r, m_r);
    chk("str pending end", pending, 0);

    // Positive saturation, then reset mid-pulse
    dv = 1'b1; delta = 16'sd32767;
    tick();
    chk("sat first", pending, 32767);
    tick();
    dv = 1'b0;
    chk("sat clamp", pending, 32767);
    chk("sat pulse", pcdu, 1);
    tick();
    chk("sat no wrap", pending, 32767);
    chk("sat pulse 2nd", pcdu, 1);
    sim_rst = 1'b1;
    tick();
    chk("midrst pcdu", pcdu, 0);
    chk("midrst pending", pending, 0);
    chk("midrst busy", busy, 0);
    sim_rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pcdu || mcdu || busy) cnt++;
    end
    chk("midrst discarded", cnt, 0);

    // Most-negative code clamps to -(2^15-1)
    dv = 1'b1; delta = 16'sh8000;
    tick();
    dv = 1'b0;
    chk("nsat clamp", pending, -32767);
    tick();
    chk("nsat mcdu", mcdu, 1);
    chk("nsat step", pending, -32766);
    do_reset();
    tick();

    // No ack at all
    dv = 1'b1; delta = 16'sd2;
    tick();
    dv = 1'b0;
    tick();
    tick();
    tick();
    chk("to pulse done", pcdu, 0);
`ifdef CDU_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    chk("to not yet", tmo, 0);
    tick();
    chk("to set", tmo, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("to gap quiet", pcdu, 0);
    tick();
    chk("to next pulse", pcdu, 1);
    chk("to sticky", tmo, 1);
`else
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pcdu || mcdu || tmo) cnt++;
    end
    chk("wait forever", cnt, 0);
    chk("wait busy", busy, 1);
    chk("wait pending", pending, 1);
`endif
    do_reset();
    #1;
    chk("to cleared", tmo, 0);
    chk("end pending", pending, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
